// File: rtl/web_shooter_ctrl_if.sv
// Decoder/trigger-side signals of the web shooter controller.
// master drives selection and requests; slave is the controller.
interface web_shooter_ctrl_if #(
    parameter int CNT_W = 4
) ();
    logic [7:0]       web_sel;
    logic             trigger;
    logic             reload;
    logic [7:0]       nozzle;
    logic             busy;
    logic [CNT_W-1:0] ammo_left;
    logic             dry_fire;
    logic             sel_err;

    modport master (
        output web_sel, trigger, reload,
        input  nozzle, busy, ammo_left, dry_fire, sel_err
    );

    modport slave (
        input  web_sel, trigger, reload,
        output nozzle, busy, ammo_left, dry_fire, sel_err
    );
endinterface

// File: rtl/web_shooter_ctrl.sv
// Web shooter firing sequencer: fire pulse, cooldown lockout and per-type shot budget.
//   state | meaning
//   IDLE  | waiting for a trigger edge or reload
//   FIRE  | nozzle driven with latched selection
//   COOL  | lockout after a shot, nozzle off
module web_shooter_ctrl #(
    parameter int FIRE_CYCLES     = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CART_DEPTH      = 15,
    parameter int CNT_W           = 4
) (
    input  logic               clk,
    input  logic               reset,
    web_shooter_ctrl_if.slave  bus
);
    localparam int PH_MAX = (FIRE_CYCLES > COOLDOWN_CYCLES) ? FIRE_CYCLES : COOLDOWN_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [1:0] {IDLE, FIRE, COOL} state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] cnt [8];
    logic [7:0]       sel_q;
    logic             trigger_d;
    logic [7:0]       nozzle_q;
    logic             busy_q;
    logic             dry_q;
    logic             err_q;

    logic             trig_edge;
    logic             sel_onehot;
    logic [2:0]       sel_idx;
    logic [CNT_W-1:0] sel_cnt;
    logic             ready;

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.web_sel[i]) sel_idx = 3'(i);
        end
    end

    assign trig_edge  = bus.trigger & ~trigger_d;
    assign sel_onehot = (bus.web_sel != 8'd0) && ((bus.web_sel & (bus.web_sel - 8'd1)) == 8'd0);
    assign sel_cnt    = cnt[sel_idx];
    // The final cooldown edge doubles as an IDLE decision so back-to-back shots lose no cycle.
    assign ready      = (state == IDLE) || ((state == COOL) && (phase == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            sel_q     <= 8'd0;
            trigger_d <= 1'b1;
            nozzle_q  <= 8'd0;
            busy_q    <= 1'b0;
            dry_q     <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 8; i++) cnt[i] <= CNT_W'(CART_DEPTH);
        end else begin
            trigger_d <= bus.trigger;
            dry_q     <= 1'b0;
            err_q     <= 1'b0;
            if (ready) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                if (bus.reload) begin
                    for (int i = 0; i < 8; i++) cnt[i] <= CNT_W'(CART_DEPTH);
                end else if (trig_edge) begin
                    if (!sel_onehot) begin
                        err_q <= 1'b1;
                    end else if (sel_cnt == '0) begin
                        dry_q <= 1'b1;
                    end else begin
                        sel_q        <= bus.web_sel;
                        cnt[sel_idx] <= sel_cnt - CNT_W'(1);
                        nozzle_q     <= bus.web_sel;
                        busy_q       <= 1'b1;
                        phase        <= PH_W'(FIRE_CYCLES - 1);
                        state        <= FIRE;
                    end
                end
            end else begin
                case (state)
                    FIRE: begin
                        if (phase == '0) begin
                            nozzle_q <= 8'd0;
                            phase    <= PH_W'(COOLDOWN_CYCLES - 1);
                            state    <= COOL;
                        end else begin
                            nozzle_q <= sel_q;
                            phase    <= phase - PH_W'(1);
                        end
                    end
                    COOL:    phase <= phase - PH_W'(1);
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.nozzle    = nozzle_q;
    assign bus.busy      = busy_q;
    assign bus.dry_fire  = dry_q;
    assign bus.sel_err   = err_q;
    assign bus.ammo_left = sel_onehot ? sel_cnt : '0;
endmodule

// File: tb/tb_web_shooter_ctrl.sv
// Self-checking bench for web_shooter_ctrl: vector table through a scoreboard
// plus hand sequences for lockout, empty/reload, reload in cooldown and reset mid-fire.
module tb_web_shooter_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   model_cnt [8];

    web_shooter_ctrl_if #(.CNT_W(4)) bus ();

    web_shooter_ctrl #(
        .FIRE_CYCLES(4), .COOLDOWN_CYCLES(8), .CART_DEPTH(15), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] sel;
        logic       reload;
        logic       fire;
        logic       dry;
        logic       err;
        logic [3:0] ammo;
    } vec_t;

    vec_t tbl [8];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [7:0] s);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) if (s[i]) r = i;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && bus.busy === 1'b1; k++) begin
            @(negedge clk);
            bus.trigger = 1'b0;
            bus.reload  = 1'b0;
            step();
        end
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic check_all();
        logic [7:0] s;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            s = 8'd1 << i;
            bus.web_sel = s;
            #1;
            chk($sformatf("ammo_type%0d", i), bus.ammo_left, model_cnt[i]);
        end
    endtask

    task automatic do_shot(input vec_t v);
        vec_t e;
        int   n_noz;
        int   n_busy;
        @(negedge clk);
        bus.web_sel = v.sel;
        bus.trigger = 1'b0;
        bus.reload  = 1'b0;
        step();
        @(negedge clk);
        bus.trigger = 1'b1;
        bus.reload  = v.reload;
        sb.push_back(v);
        step();
        e = sb.pop_front();
        chk("shot_nozzle", bus.nozzle, e.fire ? e.sel : 8'd0);
        chk("shot_busy", bus.busy, e.fire);
        chk("shot_dry_fire", bus.dry_fire, e.dry);
        chk("shot_sel_err", bus.sel_err, e.err);
        chk("shot_ammo", bus.ammo_left, e.ammo);
        n_noz  = 0;
        n_busy = 0;
        for (int k = 0; k < 40 && bus.busy === 1'b1; k++) begin
            if (bus.nozzle === e.sel) n_noz++;
            n_busy++;
            @(negedge clk);
            bus.trigger = 1'b0;
            bus.reload  = 1'b0;
            step();
        end
        if (e.fire) begin
            chk("fire_len", n_noz, 4);
            chk("busy_len", n_busy, 12);
        end
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.reload  = 1'b0;
        step();
        chk("pulse_end", {bus.dry_fire, bus.sel_err, bus.nozzle}, 10'd0);
        if (e.reload) begin
            for (int i = 0; i < 8; i++) model_cnt[i] = 15;
        end else if (e.fire) begin
            model_cnt[idx_of(e.sel)]--;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) model_cnt[i] = 15;

        tbl[0] = '{8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14};
        tbl[1] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[3] = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15};
        tbl[4] = '{8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14};
        tbl[5] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14};
        tbl[6] = '{8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13};
        tbl[7] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};

        reset       = 1'b1;
        bus.web_sel = 8'd0;
        bus.trigger = 1'b0;
        bus.reload  = 1'b0;
        repeat (3) step();
        chk("rst_outputs", {bus.nozzle, bus.busy, bus.dry_fire, bus.sel_err}, 11'd0);
        @(negedge clk);
        reset = 1'b0;
        check_all();

        for (int t = 0; t < 8; t++) do_shot(tbl[t]);
        check_all();

        // Lockout: ignored rise at +3 with web_sel wiggling, accepted rise at +12
        @(negedge clk);
        bus.web_sel = 8'h04;
        bus.trigger = 1'b0;
        step();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            bus.trigger = (c == 0 || c == 3 || c == 12);
            bus.web_sel = (c == 1 || c == 2) ? 8'h80 : 8'h04;
            step();
            chk($sformatf("lock_nozzle_c%0d", c), bus.nozzle,
                (c <= 3 || (c >= 12 && c <= 15)) ? 8'h04 : 8'h00);
            chk($sformatf("lock_busy_c%0d", c), bus.busy, 1'b1);
            chk($sformatf("lock_pulses_c%0d", c), {bus.dry_fire, bus.sel_err}, 2'b00);
        end
        wait_idle();
        model_cnt[2] -= 2;
        check_all();

        // Empty cartridge on type 7, then reload
        do_shot('{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15});
        for (int s = 0; s < 15; s++)
            do_shot('{8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'(14 - s)});
        do_shot('{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        check_all();
        do_shot('{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15});
        check_all();

        // Reload asserted mid-cooldown must be ignored
        @(negedge clk);
        bus.web_sel = 8'h01;
        bus.trigger = 1'b0;
        step();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            bus.trigger = (c == 0);
            bus.reload  = (c == 6);
            step();
        end
        wait_idle();
        chk("cool_reload_ammo", bus.ammo_left, 4'd14);
        model_cnt[0] = 14;

        // Reset mid-FIRE with trigger held high throughout
        @(negedge clk);
        bus.web_sel = 8'h02;
        bus.trigger = 1'b0;
        step();
        @(negedge clk);
        bus.trigger = 1'b1;
        step();
        chk("rstfire_nozzle_pre", bus.nozzle, 8'h02);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rstfire_outputs", {bus.nozzle, bus.busy}, 9'd0);
        step();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rstfire_held_c%0d", c), {bus.nozzle, bus.busy}, 9'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) model_cnt[i] = 15;
        check_all();
        do_shot('{8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
